sign_mag_acc: RTL
=================

# sign_mag_acc

Sequential sign-magnitude accumulator. It accepts a stream of N-bit sign-magnitude operands over a valid/ready handshake and adds or subtracts each one into an internal sign-magnitude accumulator. Subtraction is handled by inverting the operand sign. The block is the stateful counterpart to the combinational sign-magnitude adder: it owns the subtract direction, saturation and zero normalization. It sits downstream of any sign-magnitude data source and drives a registered running result.

## Interface
- N, default 8: total word width; bit N-1 is the sign (1 = negative), bits N-2:0 are the magnitude.
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present on data/op/clr.
- in_ready  output  1  block can accept an operand this cycle.
- data  input  N  sign-magnitude operand.
- op  input  1  0 = add operand, 1 = subtract operand.
- clr  input  1  load operand into the accumulator instead of combining; clears ovf.
- acc  output  N  registered accumulator value, sign-magnitude.
- out_valid  output  1  one-cycle pulse: acc has just been updated.
- ovf  output  1  sticky saturation flag.

## Operation
- States: IDLE, CALC, WRITE.
- IDLE: in_ready=1. When in_valid=1, the operand is accepted. It moves to CALC and data/op/clr are latched.
- CALC: in_ready=0. Effective operand sign = data[N-1] XOR op. Compare the magnitudes of acc and the operand, then register:
  - max and min magnitudes;
  - result sign = sign of the larger magnitude;
  - same-sign flag.
  - Always goes to WRITE.
- WRITE: in_ready=0. Compute the new acc and go to IDLE.
  - Same sign: sum = max + min, computed N bits wide. If the carry into bit N-1 is set, magnitude saturates to all ones and ovf is set.
  - Different sign: magnitude = max - min.
  - Equal magnitudes with different signs give +0.
  - clr=1: acc = latched operand with the op-adjusted sign applied. The CALC arithmetic is ignored and ovf is cleared.
- Zero normalization: a result magnitude of 0 always stores sign 0, so acc never holds -0. An input -0 behaves as +0.
- ovf stays set until reset or a clr load.
- in_valid is ignored outside IDLE. The source must hold data until in_ready=1.

## Timing
- Reset (synchronous, any state, including mid-CALC or mid-WRITE):
  - state=IDLE, acc=0, ovf=0, out_valid=0, in_ready=1 in the following cycle.
  - An operation in flight is discarded.
- Accept at edge E0 (IDLE, in_valid=1) → CALC in the cycle after E0 → WRITE after E1 → acc and ovf update at E2.
- out_valid=1 in the cycle after E2 only. in_ready=1 in that same cycle.
- Latency: acc reflects an operand 2 edges after acceptance.
- Throughput: one operand per 3 cycles.
- Back-to-back: an operand held valid is accepted at E3. No bubble beyond the IDLE cycle.
- acc and ovf are registers and change only at the WRITE→IDLE edge or at reset.

## Test plan
- Reset → acc=0x00, ovf=0, in_ready=1, out_valid=0. Then add 0x05 → acc=0x05 exactly 2 edges after accept, with a one-cycle out_valid pulse.
- From acc=0x05:
  - subtract 0x0C → acc=0x87 (-7);
  - then add 0x87 → acc=0x8E (-14);
  - then add 0x0E → acc=0x00 (+0, never 0x80).
- Saturation and clear:
  - clr load of 0x64 (+100) → acc=0x64, ovf=0;
  - add 0x32 (+50) → acc=0x7F, ovf=1;
  - subtract 0x01 → acc=0x7E with ovf still 1;
  - clr load 0x00 → ovf=0.
- Negative-zero input: acc=0x83, add 0x80 and subtract 0x80 → acc stays 0x83, ovf unchanged.
- Handshake:
  - in_valid held high with changing data during CALC/WRITE → only the operand present at the IDLE accept edge is used;
  - a held operand is accepted at E3;
  - in_ready=0 throughout CALC and WRITE.
- Reset asserted in CALC after acc=0x10 and an accepted add of 0x05 → next cycle IDLE, acc=0x00, no out_valid pulse.

Source files
------------

// File: rtl/sign_mag_acc_if.sv
// ============================================================================
//  Module   : sign_mag_acc_if
//  Purpose  : Operand handshake and result bus for the sign-magnitude
//             accumulator. The source drives the master side and the
//             accumulator implements the slave side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sign_mag_acc_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] data;
  logic         op;
  logic         clr;
  logic [N-1:0] acc;
  logic         out_valid;
  logic         ovf;

  // Operand source / result consumer
  modport master (
    output in_valid, data, op, clr,
    input  in_ready, acc, out_valid, ovf
  );

  // Accumulator
  modport slave (
    input  in_valid, data, op, clr,
    output in_ready, acc, out_valid, ovf
  );
endinterface

`default_nettype wire

// File: rtl/sign_mag_acc.sv
// ============================================================================
//  Module   : sign_mag_acc
//  Purpose  : Sequential sign-magnitude accumulator. Each accepted operand is
//             added (op=0) or subtracted (op=1) into a registered
//             sign-magnitude accumulator, or loaded into it (clr=1). Results
//             saturate to the largest magnitude and raise a sticky ovf flag.
//             Zero results are always stored as +0.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sign_mag_acc #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          reset,
  sign_mag_acc_if.slave bus
);

  localparam int M = N - 1;  // magnitude width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched operand
  logic [N-1:0] opnd_q, opnd_d;
  logic         op_q, op_d;
  logic         clr_q, clr_d;

  // Magnitude comparison results captured in CALC
  logic [M-1:0] max_q, max_d;
  logic [M-1:0] min_q, min_d;
  logic         rsign_q, rsign_d;
  logic         same_q, same_d;

  // Architectural outputs
  logic [N-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_o;

  // Combinational helpers
  logic [M-1:0] acc_mag;
  logic         acc_sign;
  logic [M-1:0] opnd_mag;
  logic         eff_sign;
  logic [N-1:0] sum;
  logic [M-1:0] diff;
  logic [M-1:0] res_mag;
  logic         res_sign;

  assign acc_mag  = acc_q[M-1:0];
  assign acc_sign = acc_q[N-1];
  assign opnd_mag = opnd_q[M-1:0];
  // Subtraction flips the operand sign; a -0 operand is folded to +0 so it
  // never alters the sign of the result.
  assign eff_sign = (opnd_q[N-1] ^ op_q) & (|opnd_mag);
  // One spare bit above the magnitude catches the same-sign carry.
  assign sum      = {1'b0, max_q} + {1'b0, min_q};
  assign diff     = max_q - min_q;

  assign bus.in_ready  = in_ready_o;
  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake output
  always_comb begin
    state_d    = state_q;
    in_ready_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready_o = 1'b1;
        if (bus.in_valid) begin
          state_d = S_CALC;
        end
      end
      S_CALC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: latch in IDLE, compare in CALC, combine in WRITE
  always_comb begin
    opnd_d      = opnd_q;
    op_d        = op_q;
    clr_d       = clr_q;
    max_d       = max_q;
    min_d       = min_q;
    rsign_d     = rsign_q;
    same_d      = same_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    res_mag     = '0;
    res_sign    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          opnd_d = bus.data;
          op_d   = bus.op;
          clr_d  = bus.clr;
        end
      end

      S_CALC: begin
        same_d = (acc_sign == eff_sign);
        if (acc_mag >= opnd_mag) begin
          max_d   = acc_mag;
          min_d   = opnd_mag;
          rsign_d = acc_sign;
        end else begin
          max_d   = opnd_mag;
          min_d   = acc_mag;
          rsign_d = eff_sign;
        end
      end

      S_WRITE: begin
        out_valid_d = 1'b1;
        if (clr_q) begin
          res_mag  = opnd_mag;
          res_sign = eff_sign;
          ovf_d    = 1'b0;
        end else if (same_q) begin
          res_sign = rsign_q;
          if (sum[M]) begin
            res_mag = {M{1'b1}};
            ovf_d   = 1'b1;
          end else begin
            res_mag = sum[M-1:0];
          end
        end else begin
          res_sign = rsign_q;
          res_mag  = diff;
        end
        // A zero magnitude is always stored with a positive sign.
        acc_d = {res_sign & (|res_mag), res_mag};
      end

      default: begin
        out_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      opnd_q      <= '0;
      op_q        <= 1'b0;
      clr_q       <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
      rsign_q     <= 1'b0;
      same_q      <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      clr_q       <= clr_d;
      max_q       <= max_d;
      min_q       <= min_d;
      rsign_q     <= rsign_d;
      same_q      <= same_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

`default_nettype wire
